// File: rtl/gac_pkg.sv
// Shared definitions for the gate access controller: control-flit op codes,
// register map, flit field positions and scheduler state encodings.
package gac_pkg;

    typedef enum logic [1:0] {
        DIS_S    = 2'd0,
        CLOSED_S = 2'd1,
        OPEN_S   = 2'd2
    } sched_state_e;

    localparam logic [3:0] OP_WRITE    = 4'hA;
    localparam logic [3:0] OP_READ     = 4'h9;
    localparam logic [3:0] OP_READ_RSP = 4'hB;

    localparam logic [27:0] ADDR_GATE_EN    = 28'd0;
    localparam logic [27:0] ADDR_CYCLE_LEN  = 28'd1;
    localparam logic [27:0] ADDR_OPEN_START = 28'd2;
    localparam logic [27:0] ADDR_OPEN_END   = 28'd3;
    localparam logic [27:0] ADDR_STATS_WIN  = 28'd4;
    localparam logic [27:0] ADDR_STATS_TOT  = 28'd5;
    localparam logic [27:0] ADDR_STATS_CLR  = 28'd6;

    localparam int HDR_HI   = 133;
    localparam int HDR_LO   = 128;
    localparam int OP_HI    = 127;
    localparam int OP_LO    = 124;
    localparam int ROUTE_HI = 123;
    localparam int ROUTE_LO = 96;
    localparam int ID_HI    = 95;
    localparam int ID_LO    = 92;
    localparam int ADDR_HI  = 91;
    localparam int ADDR_LO  = 64;
    localparam int DATA_HI  = 63;
    localparam int DATA_LO  = 0;

endpackage

// File: rtl/gac_sched.sv
// Transmission-window scheduler: shadowed window registers, period counter and
// the DIS/CLOSED/OPEN state machine that emits the registered boundary pulses.
module gac_sched
    import gac_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gate_en_i,
    input  logic [31:0] cycle_len_i,
    input  logic [31:0] open_start_i,
    input  logic [31:0] open_end_i,
    output logic        sent_start_o,
    output logic        sent_end_o,
    output logic        win_open_o
);

    sched_state_e state_q, state_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [31:0]  len_sh_q, len_sh_d;
    logic [31:0]  start_sh_q, start_sh_d;
    logic [31:0]  end_sh_q, end_sh_d;
    logic         sent_start_q, sent_start_d;
    logic         sent_end_q, sent_end_d;
    logic         last_cnt;
    logic         end_hit;

    assign last_cnt = (cnt_q == len_sh_q - 32'd1);
    // An end point beyond the period closes the window on the last count instead.
    assign end_hit  = (end_sh_q >= len_sh_q) ? last_cnt : (cnt_q == end_sh_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_sh_d     = len_sh_q;
        start_sh_d   = start_sh_q;
        end_sh_d     = end_sh_q;
        sent_start_d = 1'b0;
        sent_end_d   = 1'b0;
        case (state_q)
            CLOSED_S, OPEN_S: begin
                cnt_d = last_cnt ? '0 : cnt_q + 32'd1;
                if (last_cnt) begin
                    len_sh_d   = cycle_len_i;
                    start_sh_d = open_start_i;
                    end_sh_d   = open_end_i;
                end
                // A zero-length period loaded at the wrap has no meaning, so park in DIS_S.
                if (!gate_en_i || (last_cnt && cycle_len_i == '0)) begin
                    state_d    = DIS_S;
                    cnt_d      = '0;
                    sent_end_d = (state_q == OPEN_S);
                end else if (state_q == CLOSED_S) begin
                    if (cnt_q == start_sh_q && start_sh_q != end_sh_q) begin
                        state_d      = OPEN_S;
                        sent_start_d = 1'b1;
                    end
                end else if (end_hit) begin
                    state_d    = CLOSED_S;
                    sent_end_d = 1'b1;
                end
            end
            default: begin
                cnt_d      = '0;
                len_sh_d   = cycle_len_i;
                start_sh_d = open_start_i;
                end_sh_d   = open_end_i;
                if (gate_en_i && cycle_len_i != '0) begin
                    state_d = CLOSED_S;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= DIS_S;
            cnt_q        <= '0;
            len_sh_q     <= '0;
            start_sh_q   <= '0;
            end_sh_q     <= '0;
            sent_start_q <= 1'b0;
            sent_end_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_sh_q     <= len_sh_d;
            start_sh_q   <= start_sh_d;
            end_sh_q     <= end_sh_d;
            sent_start_q <= sent_start_d;
            sent_end_q   <= sent_end_d;
        end
    end

    assign sent_start_o = sent_start_q;
    assign sent_end_o   = sent_end_q;
    assign win_open_o   = (state_q == OPEN_S);

endmodule

// File: rtl/gac.sv
// Gate access controller: registered md/PHV forwarding to scm, control-chain
// register access and the window scheduler. GAC_STATS_EN adds md traffic counters.
module gac
    import gac_pkg::*;
#(
    parameter logic [3:0]  MODULE_ID     = 4'h6,
    parameter logic [31:0] DEF_CYCLE_LEN = 32'd1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [255:0]  in_gac_md,
    input  logic          in_gac_md_wr,
    output logic          out_gac_md_alf,
    input  logic [1023:0] in_gac_phv,
    input  logic          in_gac_phv_wr,
    output logic          out_gac_phv_alf,
    output logic [255:0]  out_gac_md,
    output logic          out_gac_md_wr,
    input  logic          in_gac_md_alf,
    output logic [1023:0] out_gac_phv,
    output logic          out_gac_phv_wr,
    input  logic          in_gac_phv_alf,
    output logic          gac2scm_sent_start,
    output logic          gac2scm_sent_end,
    input  logic [133:0]  cin_gac_data,
    input  logic          cin_gac_data_wr,
    output logic          cout_gac_ready,
    output logic [133:0]  cout_gac_data,
    output logic          cout_gac_data_wr,
    input  logic          cin_gac_ready
);

    logic [255:0]  md_q;
    logic          md_wr_q;
    logic [1023:0] phv_q;
    logic          phv_wr_q;
    logic          gate_en_q, gate_en_d;
    logic [31:0]   cycle_len_q, cycle_len_d;
    logic [31:0]   open_start_q, open_start_d;
    logic [31:0]   open_end_q, open_end_d;
    logic [133:0]  cout_data_q, cout_data_d;
    logic          cout_wr_q, cout_wr_d;
    logic [63:0]   rdata;
    logic [27:0]   cin_addr;
    logic [63:0]   cin_wdata;
    logic          claim;
    logic          reg_wr;
    logic          reg_rd;

    assign out_gac_md_alf  = in_gac_md_alf;
    assign out_gac_phv_alf = in_gac_phv_alf;
    assign cout_gac_ready  = cin_gac_ready;

    assign cin_addr  = cin_gac_data[ADDR_HI:ADDR_LO];
    assign cin_wdata = cin_gac_data[DATA_HI:DATA_LO];
    assign claim     = cin_gac_data_wr && (cin_gac_data[ID_HI:ID_LO] == MODULE_ID);
    assign reg_wr    = claim && (cin_gac_data[OP_HI:OP_LO] == OP_WRITE);
    assign reg_rd    = claim && (cin_gac_data[OP_HI:OP_LO] == OP_READ);

`ifdef GAC_STATS_EN
    logic        win_open;
    logic        stats_clr;
    logic [31:0] win_md_q, win_md_d;
    logic [31:0] tot_md_q, tot_md_d;

    assign stats_clr = reg_wr && (cin_addr == ADDR_STATS_CLR);

    always_comb begin
        win_md_d = win_md_q + {31'd0, in_gac_md_wr && win_open};
        tot_md_d = tot_md_q + {31'd0, in_gac_md_wr};
        if (stats_clr) begin
            win_md_d = '0;
            tot_md_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_md_q <= '0;
            tot_md_q <= '0;
        end else begin
            win_md_q <= win_md_d;
            tot_md_q <= tot_md_d;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (cin_addr)
            ADDR_GATE_EN:    rdata = {63'd0, gate_en_q};
            ADDR_CYCLE_LEN:  rdata = {32'd0, cycle_len_q};
            ADDR_OPEN_START: rdata = {32'd0, open_start_q};
            ADDR_OPEN_END:   rdata = {32'd0, open_end_q};
`ifdef GAC_STATS_EN
            ADDR_STATS_WIN:  rdata = {32'd0, win_md_q};
            ADDR_STATS_TOT:  rdata = {32'd0, tot_md_q};
`endif
            default:         rdata = '0;
        endcase
    end

    // Claimed writes are consumed; reads turn into a response in place of the request.
    always_comb begin
        gate_en_d    = gate_en_q;
        cycle_len_d  = cycle_len_q;
        open_start_d = open_start_q;
        open_end_d   = open_end_q;
        if (reg_wr) begin
            case (cin_addr)
                ADDR_GATE_EN:    gate_en_d    = cin_wdata[0];
                ADDR_CYCLE_LEN:  cycle_len_d  = cin_wdata[31:0];
                ADDR_OPEN_START: open_start_d = cin_wdata[31:0];
                ADDR_OPEN_END:   open_end_d   = cin_wdata[31:0];
                default:         ;
            endcase
        end
        cout_wr_d   = cin_gac_data_wr && !reg_wr;
        cout_data_d = cin_gac_data;
        if (reg_rd) begin
            cout_data_d = {cin_gac_data[HDR_HI:HDR_LO], OP_READ_RSP,
                           cin_gac_data[ROUTE_HI:ROUTE_LO], cin_gac_data[ID_HI:ID_LO],
                           cin_addr, rdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            md_q         <= '0;
            md_wr_q      <= 1'b0;
            phv_q        <= '0;
            phv_wr_q     <= 1'b0;
            gate_en_q    <= 1'b0;
            cycle_len_q  <= DEF_CYCLE_LEN;
            open_start_q <= 32'd0;
            open_end_q   <= 32'd100;
            cout_data_q  <= '0;
            cout_wr_q    <= 1'b0;
        end else begin
            md_q         <= in_gac_md;
            md_wr_q      <= in_gac_md_wr;
            phv_q        <= in_gac_phv;
            phv_wr_q     <= in_gac_phv_wr;
            gate_en_q    <= gate_en_d;
            cycle_len_q  <= cycle_len_d;
            open_start_q <= open_start_d;
            open_end_q   <= open_end_d;
            cout_data_q  <= cout_data_d;
            cout_wr_q    <= cout_wr_d;
        end
    end

    assign out_gac_md       = md_q;
    assign out_gac_md_wr    = md_wr_q;
    assign out_gac_phv      = phv_q;
    assign out_gac_phv_wr   = phv_wr_q;
    assign cout_gac_data    = cout_data_q;
    assign cout_gac_data_wr = cout_wr_q;

    gac_sched u_sched (
        .clk          (clk),
        .rst_n        (rst_n),
        .gate_en_i    (gate_en_q),
        .cycle_len_i  (cycle_len_q),
        .open_start_i (open_start_q),
        .open_end_i   (open_end_q),
        .sent_start_o (gac2scm_sent_start),
        .sent_end_o   (gac2scm_sent_end),
`ifdef GAC_STATS_EN
        .win_open_o   (win_open)
`else
        .win_open_o   ()
`endif
    );

endmodule

// File: doc/gac.md
# gac

Gate access controller: the stage directly upstream of `scm`. It forwards metadata/PHV to `scm` through one register stage. It also runs a programmable periodic transmission window and marks its boundaries to `scm` with `gac2scm_sent_start` / `gac2scm_sent_end` pulses. Window registers are read and written over the 134-bit control daisy chain; flits for other modules pass through unchanged.

## Interface
Parameters:
- `MODULE_ID`, 4'h6: control-flit module id claimed by this block.
- `DEF_CYCLE_LEN`, 32'd1000: reset value of CYCLE_LEN.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset is synchronous and active-low.
- `in_gac_md` in 256, `in_gac_md_wr` in 1, `out_gac_md_alf` out 1: metadata from upstream.
- `in_gac_phv` in 1024, `in_gac_phv_wr` in 1, `out_gac_phv_alf` out 1: PHV from upstream.
- `out_gac_md` out 256, `out_gac_md_wr` out 1, `in_gac_md_alf` in 1: metadata to `scm`.
- `out_gac_phv` out 1024, `out_gac_phv_wr` out 1, `in_gac_phv_alf` in 1: PHV to `scm`.
- `gac2scm_sent_start` out 1, `gac2scm_sent_end` out 1: one-cycle window-boundary pulses.
- `cin_gac_data` in 134, `cin_gac_data_wr` in 1, `cout_gac_ready` out 1: control in.
- `cout_gac_data` out 134, `cout_gac_data_wr` out 1, `cin_gac_ready` in 1: control out.

## Operation
- **Datapath**
  - `out_*`/`out_*_wr` register `in_*`/`in_*_wr` every cycle.
  - `out_gac_md_alf` = `in_gac_md_alf` and `out_gac_phv_alf` = `in_gac_phv_alf`, combinational.
- **Control flit fields**
  - [133:128] header, echoed unchanged; [127:124] op (4'hA write, 4'h9 read, 4'hB read response).
  - [123:96] routing, echoed; [95:92] module id; [91:64] register address; [63:0] data.
- **Control handling**
  - `cout_gac_ready` = `cin_gac_ready`, combinational.
  - A flit with id ≠ `MODULE_ID`, or with an op other than A/9, is forwarded unchanged.
  - A matching write updates the register and emits no output flit.
  - A matching read emits the same flit with op = 4'hB and data = register value, zero-extended; an unknown address returns 0.
  - Writes to read-only or unknown addresses are ignored.
- **Registers**
  - 0 GATE_EN, bit 0, reset 0.
  - 1 CYCLE_LEN, reset `DEF_CYCLE_LEN`.
  - 2 OPEN_START, reset 0.
  - 3 OPEN_END, reset 100.
  - CYCLE_LEN, OPEN_START and OPEN_END are 32-bit and shadowed: written values take effect at the next period wrap, or when GATE_EN goes 0→1.
- **Scheduler state machine** (32-bit period counter `cnt`)
  - DIS_S: counter held at 0. On GATE_EN=1 with shadowed CYCLE_LEN≠0, go to CLOSED_S with `cnt`=0.
  - CLOSED_S: `cnt` counts 0..CYCLE_LEN−1 and then wraps. When `cnt`==OPEN_START, pulse `sent_start` and go to OPEN_S.
  - OPEN_S: when `cnt`==OPEN_END, pulse `sent_end` and go to CLOSED_S. If OPEN_END ≥ CYCLE_LEN, `sent_end` fires at `cnt`==CYCLE_LEN−1 instead.
  - OPEN_START==OPEN_END is a degenerate window: no pulses, stay in CLOSED_S.
  - OPEN_START ≥ CYCLE_LEN: the window never opens.
  - GATE_EN written to 0 in OPEN_S: pulse `sent_end` next cycle, then DIS_S. In CLOSED_S: go to DIS_S with no pulse.
  - `sent_start` and `sent_end` are never high in the same cycle.

## Timing
- Reset values:
  - All `out_*` data, `*_wr` strobes, pulses and `cout_gac_data_wr` are 0.
  - `cout_gac_data` = 0; state DIS_S; `cnt` = 0.
- Latencies:
  - Datapath and control flit: 1 cycle.
  - Register write visible to reads on the next cycle; visible to the scheduler at the next wrap.
  - GATE_EN write to first `cnt`=0: 1 cycle.
- Pulse timing: a pulse is asserted in the cycle after the `cnt` match, as a registered output.
- Reset mid-window: no `sent_end` is issued; `scm` is reset by the same `rst_n`.

## Configuration
- `GAC_STATS_EN` defined:
  - Read-only 32-bit counters at addr 4 (md writes forwarded while OPEN_S) and addr 5 (total md writes).
  - Both wrap at 2^32; both clear on reset and on a write of any value to addr 6.
- `GAC_STATS_EN` undefined: addrs 4–6 read 0 and writes are ignored; no counter logic.

## Structure
- Shared package `gac_pkg` holds op codes (A/9/B), register addresses 0–6, flit field bit ranges, and state encodings DIS_S/CLOSED_S/OPEN_S.
- Sub-module `gac_sched`: shadow registers, period counter, state machine and pulse generation. Its inputs are GATE_EN and the three live registers.

## Test plan
- CYCLE_LEN=10, START=2, END=5, GATE_EN=1 → `sent_start` with `cnt`=2 and `sent_end` with `cnt`=5, every 10 cycles.
- Read flit `{6'b010000, 128'h900080076000000100...00}` → 1 cycle later `cout` carries op B with data 0x3E8.
- Flit with module id 7 → forwarded bit-exact after 1 cycle; no register changes.
- Write END=8 mid-period → the current period still ends at 5; the next period ends at 8.
- GATE_EN=0 while OPEN_S → one `sent_end` pulse, then no pulses.
- `GAC_STATS_EN` with 3 md writes inside the window and 2 outside → addr 4 reads 3, addr 5 reads 5; md/PHV appear 1 cycle after input.
